// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and load/store.
// Latency: grant in cycle T, rvalid pulse in T+MEM_LATENCY+1; one transaction in flight.
// Backpressure: ready is withheld while a transaction is outstanding; data wins ties unless fetch is starved.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_byte_mask,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_byte_mask,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0] LAT_MAX    = LAT_W'(MEM_LATENCY);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;
    logic             grant_f;
    logic             grant_d;
    logic             owner_d;   // 1: outstanding transaction belongs to the data port
    logic             owner_st;  // 1: outstanding data transaction is a store
    logic             done;      // last WAIT cycle; response is captured at its closing edge

    assign done = (state == WAIT) && (lat_cnt == LAT_MAX);

    // Arbitration, memory issue and next-state; nothing is granted while reset is held.
    always_comb begin
        state_nxt     = state;
        grant_f       = 1'b0;
        grant_d       = 1'b0;
        if_ready      = 1'b0;
        d_ready       = 1'b0;
        mem_en        = 1'b0;
        mem_wen       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_byte_mask = '0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (if_req && (!d_req || starve_cnt == STARVE_MAX)) begin
                        grant_f = 1'b1;
                    end else if (d_req) begin
                        grant_d = 1'b1;
                    end
                end
                if (grant_f) begin
                    if_ready      = 1'b1;
                    mem_en        = 1'b1;
                    mem_addr      = if_addr;
                    mem_byte_mask = 3'b010;
                    state_nxt     = WAIT;
                end else if (grant_d) begin
                    d_ready       = 1'b1;
                    mem_en        = 1'b1;
                    mem_wen       = d_wen;
                    mem_addr      = d_addr;
                    mem_wdata     = d_wdata;
                    mem_byte_mask = d_byte_mask;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latency counter: 1 in the first WAIT cycle, MEM_LATENCY in the last, back to 0 after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (grant_f || grant_d) begin
            lat_cnt <= LAT_W'(1);
        end else if (done) begin
            lat_cnt <= '0;
        end else if (state == WAIT) begin
            lat_cnt <= lat_cnt + 1'b1;
        end
    end

    // Starvation counter: data grants that bypassed a pending fetch, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_f || !if_req) begin
                starve_cnt <= '0;
            end else if (grant_d && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Remember who owns the outstanding transaction and whether it is a store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d  <= 1'b0;
            owner_st <= 1'b0;
        end else if (grant_f || grant_d) begin
            owner_d  <= grant_d;
            owner_st <= grant_d && d_wen;
        end
    end

    // Response capture: one-cycle rvalid to the owner; rdata holds until that port's next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= done && !owner_d;
            d_rvalid  <= done && owner_d;
            if (done && !owner_d) begin
                if_rdata <= mem_rdata;
            end
            if (done && owner_d) begin
                d_rdata <= owner_st ? 32'h0 : mem_rdata;
            end
        end
    end

    // busy mirrors "state is WAIT" as a register output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt == WAIT);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LATENCY 1 and 2, STARVE_LIMIT 4),
// each with its own memory, directed + random requesters and a transaction-level model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input int cfg, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %h expected %h", cfg, name, act, exp);
        end
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h00500093 : (32'hC0DE0000 + 32'(i) * 32'h00010003);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int L  = g + 1;
        localparam int SL = 4;

        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_ready;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_req;
        logic        d_wen;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [2:0]  d_byte_mask;
        logic        d_ready;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        mem_en;
        logic        mem_wen;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [2:0]  mem_byte_mask;
        logic [31:0] mem_rdata;
        logic        busy;
        bit          done_g = 1'b0;

        mem_arbiter #(.ADDR_W(32), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
            .if_rvalid(if_rvalid), .if_rdata(if_rdata),
            .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_byte_mask(d_byte_mask), .d_ready(d_ready), .d_rvalid(d_rvalid),
            .d_rdata(d_rdata),
            .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_byte_mask(mem_byte_mask),
            .mem_rdata(mem_rdata), .busy(busy)
        );

        // Memory macro: read launched at the issue edge, valid L cycles after issue; garbage otherwise.
        logic [31:0] pmem [32];
        logic [31:0] pipe [L];
        bit          pinit = 1'b0;
        assign mem_rdata = pipe[L-1];
        always @(posedge clk) begin
            if (!pinit) begin
                for (int i = 0; i < 32; i++) pmem[i] <= init_word(i);
                pinit <= 1'b1;
            end else if (mem_en && mem_wen) begin
                pmem[mem_addr[6:2]] <= mem_wdata;
            end
            pipe[0] <= mem_en ? pmem[mem_addr[6:2]] : 32'hBAD0BAD0;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end

        // Reference model: remaining cycles of the outstanding transaction plus expected responses.
        logic [31:0] mmem [32];
        initial begin : model
            int          rem;
            int          starve;
            bit          who_d;
            logic [31:0] who_data;
            logic        e_iv, e_dv, n_iv, n_dv;
            logic [31:0] e_ir, e_dd;
            logic        f, d;
            logic        e_en, e_wen;
            logic [31:0] e_addr, e_wdata;
            logic [2:0]  e_mask;
            rem = 0; starve = 0; who_d = 0; who_data = 0;
            e_iv = 0; e_dv = 0; e_ir = 0; e_dd = 0;
            for (int i = 0; i < 32; i++) mmem[i] = init_word(i);
            forever begin
                @(negedge clk);
                f = 0; d = 0; e_en = 0; e_wen = 0; e_addr = 0; e_wdata = 0; e_mask = 0;
                if (rst) begin
                    rem = 0; starve = 0; e_iv = 0; e_dv = 0; e_ir = 0; e_dd = 0;
                end else if (rem == 0) begin
                    f = if_req && (!d_req || starve == SL);
                    d = d_req && !f;
                    if (f) begin
                        e_en = 1; e_addr = if_addr; e_mask = 3'b010;
                    end else if (d) begin
                        e_en = 1; e_wen = d_wen; e_addr = d_addr;
                        e_wdata = d_wdata; e_mask = d_byte_mask;
                    end
                end
                chk(g, "if_ready", if_ready, f);
                chk(g, "d_ready", d_ready, d);
                chk(g, "mem_en", mem_en, e_en);
                chk(g, "mem_wen", mem_wen, e_wen);
                chk(g, "mem_addr", mem_addr, e_addr);
                chk(g, "mem_wdata", mem_wdata, e_wdata);
                chk(g, "mem_byte_mask", mem_byte_mask, e_mask);
                chk(g, "busy", busy, (rem > 0));
                chk(g, "if_rvalid", if_rvalid, e_iv);
                chk(g, "if_rdata", if_rdata, e_ir);
                chk(g, "d_rvalid", d_rvalid, e_dv);
                chk(g, "d_rdata", d_rdata, e_dd);
                n_iv = 0; n_dv = 0;
                if (!rst) begin
                    if (rem == 0) begin
                        if (f || !if_req) starve = 0;
                        else if (d && starve < SL) starve++;
                        if (f) begin
                            rem = L; who_d = 0; who_data = mmem[if_addr[6:2]];
                        end else if (d) begin
                            rem = L; who_d = 1;
                            who_data = d_wen ? 32'h0 : mmem[d_addr[6:2]];
                            if (d_wen) mmem[d_addr[6:2]] = d_wdata;
                        end
                    end else begin
                        rem--;
                        if (rem == 0) begin
                            if (who_d) begin n_dv = 1; e_dd = who_data; end
                            else begin n_iv = 1; e_ir = who_data; end
                        end
                    end
                end
                e_iv = n_iv; e_dv = n_dv;
            end
        end

        // Driver with directed scenarios and literal expectations.
        int          cyc = 0;
        int          s_cyc;
        logic        s_ifr, s_dr, s_en, s_iv, s_dv, s_busy;
        logic [31:0] s_ir, s_dd;

        task automatic tick();
            @(negedge clk);
            s_cyc = cyc; s_ifr = if_ready; s_dr = d_ready; s_en = mem_en;
            s_iv = if_rvalid; s_ir = if_rdata; s_dv = d_rvalid; s_dd = d_rdata; s_busy = busy;
            @(posedge clk);
            #1;
            cyc++;
        endtask

        task automatic idle(input int n);
            if_req = 0; d_req = 0;
            repeat (n) tick();
        endtask

        task automatic wait_ready(input bit want_d, output int t);
            t = -1;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (want_d ? s_dr : s_ifr) begin
                    t = s_cyc;
                    break;
                end
            end
            chk(g, want_d ? "d_grant_seen" : "if_grant_seen", (t >= 0), 1);
        endtask

        task automatic watch_resp(input bit is_d, input int t, input logic [31:0] exp);
            for (int i = 0; i < L + 1; i++) begin
                tick();
                chk(g, "other_rvalid_quiet", is_d ? s_iv : s_dv, 0);
                if (s_cyc != t + L + 1) chk(g, "rvalid_not_early", is_d ? s_dv : s_iv, 0);
            end
            chk(g, "resp_cycle", s_cyc, t + L + 1);
            chk(g, "resp_rvalid", is_d ? s_dv : s_iv, 1);
            chk(g, "resp_rdata", is_d ? s_dd : s_ir, exp);
            chk(g, "resp_busy_low", s_busy, 0);
        endtask

        initial begin : driver
            int    t, t2, dn;
            string seq;
            rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_wen = 0;
            d_addr = 0; d_wdata = 0; d_byte_mask = 0;
            tick(); tick();
            chk(g, "reset_busy", s_busy, 0);
            chk(g, "reset_if_rvalid", s_iv, 0);
            chk(g, "reset_mem_en", s_en, 0);
            rst = 0;
            idle(2);

            // Single fetch of the word at 0x10.
            if_req = 1; if_addr = 32'h10;
            wait_ready(0, t);
            chk(g, "fetch_mem_en_at_grant", s_en, 1);
            if_req = 0;
            watch_resp(0, t, 32'h00500093);

            // Store then load at 0x40.
            d_req = 1; d_wen = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_byte_mask = 3'b010;
            wait_ready(1, t);
            d_req = 0;
            watch_resp(1, t, 32'h0);
            d_req = 1; d_wen = 0;
            wait_ready(1, t);
            d_req = 0;
            watch_resp(1, t, 32'hDEADBEEF);

            // Both requests held high: starvation limit interleaves fetches.
            idle(L + 2);
            if_req = 1; if_addr = 32'h20; d_req = 1; d_wen = 0; d_addr = 32'h08;
            seq = "";
            for (int i = 0; i < 200 && seq.len() < 10; i++) begin
                tick();
                if (s_dr) seq = {seq, "D"};
                if (s_ifr) seq = {seq, "F"};
            end
            checks++;
            if (seq != "DDDDFDDDDF") begin
                errors++;
                $display("FAIL cfg%0d starve_order: got %s expected DDDDFDDDDF", g, seq);
            end

            // Data request raised during WAIT is only granted back in IDLE.
            idle(L + 2);
            if_req = 1; if_addr = 32'h14;
            wait_ready(0, t);
            if_req = 0; d_req = 1; d_wen = 0; d_addr = 32'h18;
            wait_ready(1, t2);
            chk(g, "busy_ignore_grant_cycle", t2, t + L + 1);
            idle(L + 2);

            // Fetch skipped for one IDLE cycle after 3 data grants clears the count.
            if_req = 1; if_addr = 32'h24; d_req = 1; d_wen = 0; d_addr = 32'h1C;
            seq = ""; dn = 0;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (s_dr) begin
                    seq = {seq, "D"}; dn++;
                    if (dn == 3) if_req = 0;
                    else if (dn == 4) if_req = 1;
                end
                if (s_ifr) begin
                    seq = {seq, "F"};
                    break;
                end
            end
            checks++;
            if (seq != "DDDDDDDDF") begin
                errors++;
                $display("FAIL cfg%0d starve_clear: got %s expected DDDDDDDDF", g, seq);
            end
            idle(2);

            // Reset in the middle of a store: no response, write still lands.
            d_req = 1; d_wen = 1; d_addr = 32'h7C; d_wdata = 32'h12345678; d_byte_mask = 3'b010;
            wait_ready(1, t);
            d_req = 0; d_wen = 0; rst = 1; if_req = 1; if_addr = 32'h30;
            tick();
            chk(g, "rst_busy", s_busy, 0);
            chk(g, "rst_if_ready", s_ifr, 0);
            chk(g, "rst_mem_en", s_en, 0);
            chk(g, "rst_if_rdata", s_ir, 0);
            chk(g, "rst_d_rdata", s_dd, 0);
            chk(g, "rst_d_rvalid", s_dv, 0);
            tick();
            rst = 0; if_req = 0;
            for (int i = 0; i < L + 3; i++) begin
                tick();
                chk(g, "abandoned_no_rvalid", s_dv, 0);
                chk(g, "idle_mem_en", s_en, 0);
            end
            d_req = 1; d_wen = 0;
            wait_ready(1, t);
            d_req = 0;
            watch_resp(1, t, 32'h12345678);

            // Random traffic obeying the hold-until-ready rule.
            for (int n = 0; n < 1500; n++) begin
                if (!if_req || s_ifr) begin
                    if_req = ($urandom_range(0, 99) < 45);
                    if_addr = $urandom;
                end
                if (!d_req || s_dr) begin
                    d_req = ($urandom_range(0, 99) < 55);
                    d_wen = 1'($urandom_range(0, 1));
                    d_addr = $urandom;
                    d_wdata = $urandom;
                    d_byte_mask = 3'($urandom_range(0, 7));
                end
                tick();
            end
            idle(L + 3);
            done_g = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 30000 && !(cfg[0].done_g && cfg[1].done_g); i++) @(posedge clk);
        if (!(cfg[0].done_g && cfg[1].done_g)) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got %b%b expected 11", cfg[1].done_g, cfg[0].done_g);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the RV32I core. It shares one unified instruction/data memory between the fetch port and the load/store port. Each transaction is granted with a ready handshake, issued to memory, and completed with a one-cycle response pulse. Data accesses take priority, and a starvation limit guarantees fetch progress. The block sits between PC/fetch logic, the load/store path and the memory macro; it lets the core move from split IMEM/DMEM to one shared memory.

## Interface
- ADDR_W, 32, address width of all ports
- MEM_LATENCY, 1, cycles from issue until mem_rdata is valid; legal range ≥1
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending; legal range ≥1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle fetch response pulse
- if_rdata  out  32  fetched instruction; valid when if_rvalid=1
- d_req  in  1  data request
- d_wen  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_byte_mask  in  3  size/sign code, passed to memory unchanged
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle data completion pulse, for loads and stores
- d_rdata  out  32  load data; 0 on store completion
- mem_en  out  1  issue strobe to memory
- mem_wen  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_byte_mask  out  3  memory byte mask
- mem_rdata  in  32  memory read data
- busy  out  1  transaction outstanding (state ≠ IDLE)

## Operation
- States:
  - IDLE: accepting requests.
  - WAIT: issued; lat_cnt counts up to MEM_LATENCY.
  - One transaction outstanding at most; no pipelining.
- Arbitration in IDLE only:
  - If only one of if_req/d_req is high, that port wins.
  - If both are high, data wins, unless starve_cnt == STARVE_LIMIT; then fetch wins.
- starve_cnt:
  - Increments on every data grant made while if_req=1, saturating at STARVE_LIMIT.
  - Clears on a fetch grant, and on any IDLE cycle with if_req=0.
- Grant cycle T, combinational:
  - Winner's ready=1; loser's ready=0.
  - mem_en=1; mem_addr/mem_wen/mem_wdata/mem_byte_mask driven from the winner.
  - A fetch grant drives mem_wen=0, mem_wdata=0, mem_byte_mask=3'b010 (word).
  - Next state is WAIT; the winner's identity is registered.
- In WAIT and in IDLE with no request:
  - mem_en=0, mem_wen=0, other mem_* outputs 0.
  - Both ready outputs 0.
- The edge ending cycle T+MEM_LATENCY:
  - Captures mem_rdata into the winner's rdata register; stores capture 0.
  - Sets the winner's rvalid for exactly one cycle.
  - State returns to IDLE.
- rdata registers hold their value until the next completion on the same port.
- Requesters hold req and payload stable until ready=1. They may drop or change them in the cycle after ready=1.
- Requests presented during WAIT are ignored and not queued.

## Timing
- Reset values: state=IDLE, lat_cnt=0, starve_cnt=0. All outputs 0, including if_rdata, d_rdata, both rvalid and both ready.
- Reset asserted mid-transaction: transaction abandoned, no rvalid is ever produced, and the memory write is not retracted. After rst deasserts, arbitration resumes in the first cycle.
- Issue-to-response latency:
  - Grant in cycle T; rvalid=1 in cycle T+MEM_LATENCY+1.
  - The block is in IDLE in T+MEM_LATENCY+1, so a new grant is possible that same cycle.
  - Peak throughput: one transaction per MEM_LATENCY+1 cycles.
- ready, mem_en and mem_* outputs are combinational from state and requests. rvalid, rdata and busy are registered.
- busy=1 from cycle T+1 through T+MEM_LATENCY; busy=0 in the rvalid cycle.
- Both requests high with starve_cnt < STARVE_LIMIT: data granted; starve_cnt increments.
- Both high with starve_cnt == STARVE_LIMIT: fetch granted; starve_cnt cleared.
- lat_cnt width is $clog2(MEM_LATENCY+1) and it never wraps.

## Test plan
- Reset / idle:
  - Stimulus: assert rst mid-WAIT; then release rst with no requests.
  - Required: all outputs 0 immediately on assert; busy=0; no rvalid ever for the abandoned transaction; mem_en stays 0 while idle.
- Single fetch, MEM_LATENCY=1:
  - Stimulus: if_addr=0x10, memory word 0x00500093.
  - Required: if_ready and mem_en in cycle T; if_rvalid=1 with if_rdata=0x00500093 in T+2; d_rvalid=0 throughout.
- Store then load, MEM_LATENCY=2:
  - Stimulus: store 0xDEADBEEF to 0x40, then load from 0x40.
  - Required: store d_rvalid at T+3 with d_rdata=0; load d_rvalid at T'+3 with d_rdata=0xDEADBEEF.
- Simultaneous requests, STARVE_LIMIT=4:
  - Stimulus: if_req and d_req held high continuously.
  - Required: grant order D,D,D,D,F,D,D,D,D,F; no cycle with both ready outputs high.
- Ignored request while busy:
  - Stimulus: d_req rises during WAIT.
  - Required: d_ready=0 until the state returns to IDLE, then grant in the first IDLE cycle.
- Starvation clear:
  - Stimulus: if_req drops for one IDLE cycle after 3 data grants.
  - Required: starve_cnt resets to 0; fetch next wins only after 4 further data grants.
